// File: rtl/doodle_pkg.sv
// Shared doodle definitions: motion state type, default screen geometry and
// datapath widths. Reused by the motion controller, renderer and block manager.
// No ports.
package doodle_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRising  = 2'd1,
    StFalling = 2'd2,
    StDead    = 2'd3
  } doodle_state_e;

  localparam int unsigned ScreenWidthDef  = 320;
  localparam int unsigned ScreenHeightDef = 480;
  localparam int unsigned CoordWDef       = 16;
  localparam int unsigned VelWDef         = 8;

endpackage

// File: rtl/doodle_hwrap.sv
// Combinational horizontal step with screen wrap-around.
// Ports:
//   x      - current x (0..SCREEN_WIDTH-1)
//   left   - steer left
//   right  - steer right
//   x_next - x after one step; held when both or neither steer input is set
module doodle_hwrap
  import doodle_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH = ScreenWidthDef,
  parameter int unsigned H_SPEED      = 2,
  parameter int unsigned COORD_W      = CoordWDef
) (
  input  logic [COORD_W-1:0] x,
  input  logic               left,
  input  logic               right,
  output logic [COORD_W-1:0] x_next
);

  localparam logic [COORD_W-1:0] Step  = COORD_W'(H_SPEED);
  localparam logic [COORD_W-1:0] Width = COORD_W'(SCREEN_WIDTH);

  // One extra bit so x + Step cannot overflow before the wrap compare.
  logic [COORD_W:0] x_plus;
  assign x_plus = {1'b0, x} + {1'b0, Step};

  always_comb begin
    x_next = x;
    if (left && !right) begin
      if (x < Step) x_next = x + Width - Step;
      else          x_next = x - Step;
    end else if (right && !left) begin
      if (x_plus >= {1'b0, Width}) x_next = x + Step - Width;
      else                         x_next = x + Step;
    end
  end

endmodule

// File: rtl/doodle_motion_ctrl.sv
// Doodle physics engine: position, signed vertical velocity with gravity,
// horizontal steering with wrap, camera-scroll requests and game-over.
// Optional feature macro: DOODLE_SPRING_EN (adds the spring input; a landing
// with spring high loads SPRING_VELOCITY instead of JUMP_VELOCITY).
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   tick                  - physics strobe; motion updates only on tick
//   start                 - leave IDLE / restart from DEAD (no tick needed)
//   left, right           - steering
//   collide               - feet overlap a block this tick (used while falling)
//   spring                - (DOODLE_SPRING_EN only) spring landing
//   x, y                  - position, y screen-relative
//   vy                    - signed vertical velocity
//   falling               - state is FALLING
//   scroll_valid          - one-cycle pulse, scroll_dy valid
//   scroll_dy             - amount the world must move down
//   game_over             - one-cycle pulse on entry to DEAD
module doodle_motion_ctrl
  import doodle_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH    = ScreenWidthDef,
  parameter int unsigned SCREEN_HEIGHT   = ScreenHeightDef,
  parameter int unsigned COORD_W         = CoordWDef,
  parameter int unsigned VEL_W           = VelWDef,
  parameter int unsigned JUMP_VELOCITY   = 12,
  parameter int unsigned GRAVITY         = 1,
  parameter int unsigned MAX_FALL_SPEED  = 12,
  parameter int unsigned H_SPEED         = 2,
  parameter int unsigned SCROLL_LINE     = 320,
  parameter int unsigned SPRING_VELOCITY = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               left,
  input  logic               right,
  input  logic               collide,
`ifdef DOODLE_SPRING_EN
  input  logic               spring,
`endif
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [VEL_W-1:0]   vy,
  output logic               falling,
  output logic               scroll_valid,
  output logic [COORD_W-1:0] scroll_dy,
  output logic               game_over
);

  localparam logic [COORD_W-1:0]      XHome      = COORD_W'(SCREEN_WIDTH / 2);
  localparam logic [COORD_W-1:0]      ScrollLine = COORD_W'(SCROLL_LINE);
  localparam logic signed [COORD_W:0] ScrollLineS = $signed({1'b0, ScrollLine});
  localparam logic [VEL_W-1:0]        JumpVel    = VEL_W'(JUMP_VELOCITY);
  localparam logic signed [VEL_W:0]   Grav       = $signed((VEL_W + 1)'(GRAVITY));
  localparam logic signed [VEL_W:0]   NegMaxFall = -$signed((VEL_W + 1)'(MAX_FALL_SPEED));

  doodle_state_e state_q;

  logic [COORD_W-1:0]      x_next;
  logic signed [COORD_W:0] vy_ext;
  logic signed [COORD_W:0] y_raw;
  logic signed [VEL_W:0]   vy_dec;
  logic [VEL_W-1:0]        vy_new;
  logic [VEL_W-1:0]        land_vel;
  logic                    y_under;
  logic                    y_over;
  logic                    vy_new_le0;

  doodle_hwrap #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .H_SPEED      (H_SPEED),
    .COORD_W      (COORD_W)
  ) u_hwrap (
    .x      (x),
    .left   (left),
    .right  (right),
    .x_next (x_next)
  );

  // y is unsigned; one extra bit keeps y + vy signed so a fall below 0 is visible.
  assign vy_ext = $signed({{(COORD_W + 1 - VEL_W){vy[VEL_W-1]}}, vy});
  assign y_raw  = $signed({1'b0, y}) + vy_ext;
  assign y_under = y_raw[COORD_W];
  assign y_over  = y_raw > ScrollLineS;

  // Gravity in VEL_W+1 bits so the clamp sees the true value before truncation.
  assign vy_dec     = $signed({vy[VEL_W-1], vy}) - Grav;
  assign vy_new     = (vy_dec < NegMaxFall) ? NegMaxFall[VEL_W-1:0] : vy_dec[VEL_W-1:0];
  assign vy_new_le0 = vy_new[VEL_W-1] || (vy_new == '0);

`ifdef DOODLE_SPRING_EN
  assign land_vel = spring ? VEL_W'(SPRING_VELOCITY) : JumpVel;
`else
  assign land_vel = JumpVel;
`endif

  assign falling = (state_q == StFalling);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      x            <= XHome;
      y            <= '0;
      vy           <= '0;
      scroll_valid <= 1'b0;
      scroll_dy    <= '0;
      game_over    <= 1'b0;
    end else begin
      scroll_valid <= 1'b0;
      game_over    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            vy      <= JumpVel;
            state_q <= StRising;
          end
        end
        StRising, StFalling: begin
          if (tick) begin
            x <= x_next;
            if (state_q == StFalling && collide) begin
              vy      <= land_vel;
              state_q <= StRising;
            end else if (y_under) begin
              y         <= '0;
              vy        <= '0;
              state_q   <= StDead;
              game_over <= 1'b1;
            end else begin
              vy <= vy_new;
              if (state_q == StRising && vy_new_le0) state_q <= StFalling;
              if (y_over) begin
                // y_raw is positive here, so its low bits hold the exact difference.
                y            <= ScrollLine;
                scroll_dy    <= y_raw[COORD_W-1:0] - ScrollLine;
                scroll_valid <= 1'b1;
              end else begin
                y <= y_raw[COORD_W-1:0];
              end
            end
          end
        end
        StDead: begin
          if (start) begin
            x         <= XHome;
            y         <= '0;
            scroll_dy <= '0;
            vy        <= JumpVel;
            state_q   <= StRising;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
